// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and queued load results into one registered bank write per cycle,
// and tracks per-register pending writes. Optional macro WB_FWD_EN adds busC forwarding ports.
module wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wb_stall,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [4:0]             alu_rd,
  input  logic [DW-1:0]          alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [4:0]             ld_rd,
  input  logic [DW-1:0]          ld_data,
  input  logic                   iss_valid,
  input  logic [4:0]             iss_rd,
  input  logic [4:0]             qA,
  input  logic [4:0]             qB,
  output logic                   busyA,
  output logic                   busyB,
`ifdef WB_FWD_EN
  output logic                   fwdA_hit,
  output logic                   fwdB_hit,
  output logic [DW-1:0]          fwdA_data,
  output logic [DW-1:0]          fwdB_data,
`endif
  output logic [4:0]             rd,
  output logic [DW-1:0]          busC,
  output logic [$clog2(DEPTH):0] ld_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]    r_q_rd   [DEPTH];
  logic [DW-1:0] r_q_data [DEPTH];
  logic [AW-1:0] r_wptr_p0;
  logic [AW-1:0] r_rptr_p0;
  logic [CW-1:0] r_count_p0;

  logic [4:0]    r_rd_p1;
  logic [DW-1:0] r_busc_p1;
  logic [31:0]   r_sb;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_load;
  logic [4:0]    w_wr_rd;
  logic [DW-1:0] w_wr_data;
  logic [31:0]   w_clr;
  logic [31:0]   w_set;
  logic          w_hit_a;
  logic          w_hit_b;

  assign w_full    = (r_count_p0 == CW'(DEPTH));
  assign ld_ready  = !w_full;
  assign alu_ready = !wb_stall;
  assign w_push    = ld_valid && !w_full;
  assign w_pop     = !wb_stall && !alu_valid && (r_count_p0 != '0);

  // Write selection: stall beats ALU, ALU beats the load queue; idle cycles keep busC
  always_comb begin
    w_load    = 1'b0;
    w_wr_rd   = 5'd0;
    w_wr_data = r_busc_p1;
    if (!wb_stall && alu_valid) begin
      w_load    = 1'b1;
      w_wr_rd   = alu_rd;
      w_wr_data = alu_data;
    end else if (w_pop) begin
      w_load    = 1'b1;
      w_wr_rd   = r_q_rd[r_rptr_p0];
      w_wr_data = r_q_data[r_rptr_p0];
    end
  end

  // Queue storage holds data only; occupancy lives in the control registers below
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wptr_p0]   <= ld_rd;
      r_q_data[r_wptr_p0] <= ld_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr_p0  <= '0;
      r_rptr_p0  <= '0;
      r_count_p0 <= '0;
    end else begin
      if (w_push) r_wptr_p0 <= r_wptr_p0 + 1'b1;
      if (w_pop)  r_rptr_p0 <= r_rptr_p0 + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count_p0 <= r_count_p0 + 1'b1;
        2'b01:   r_count_p0 <= r_count_p0 - 1'b1;
        default: r_count_p0 <= r_count_p0;
      endcase
    end
  end

  // ---- stage p1: registered bank write ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_p1   <= 5'd0;
      r_busc_p1 <= '0;
    end else begin
      r_rd_p1 <= w_wr_rd;
      if (w_load) r_busc_p1 <= w_wr_data;
    end
  end

  // A new issue to the same register outranks the retiring write, hence set after clear
  assign w_clr = (w_wr_rd != 5'd0) ? (32'd1 << w_wr_rd) : 32'd0;
  assign w_set = (iss_valid && iss_rd != 5'd0) ? (32'd1 << iss_rd) : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_sb <= '0;
    else       r_sb <= ((r_sb & ~w_clr) | w_set) & ~32'd1;
  end

`ifdef WB_FWD_EN
  assign w_hit_a   = (r_rd_p1 != 5'd0) && (r_rd_p1 == qA);
  assign w_hit_b   = (r_rd_p1 != 5'd0) && (r_rd_p1 == qB);
  assign fwdA_hit  = w_hit_a;
  assign fwdB_hit  = w_hit_b;
  assign fwdA_data = r_busc_p1;
  assign fwdB_data = r_busc_p1;
`else
  assign w_hit_a = 1'b0;
  assign w_hit_b = 1'b0;
`endif

  assign busyA    = r_sb[qA] && !w_hit_a;
  assign busyB    = r_sb[qB] && !w_hit_b;
  assign rd       = r_rd_p1;
  assign busC     = r_busc_p1;
  assign ld_count = r_count_p0;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios then random traffic, all checked against a
// queue-based reference model of the writeback rules. Define WB_FWD_EN to cover forwarding.
module tb_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wb_stall = 1'b0;
  logic          alu_valid = 1'b0;
  logic          alu_ready;
  logic [4:0]    alu_rd = '0;
  logic [DW-1:0] alu_data = '0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [4:0]    ld_rd = '0;
  logic [DW-1:0] ld_data = '0;
  logic          iss_valid = 1'b0;
  logic [4:0]    iss_rd = '0;
  logic [4:0]    qA = '0;
  logic [4:0]    qB = '0;
  logic          busyA;
  logic          busyB;
`ifdef WB_FWD_EN
  logic          fwdA_hit;
  logic          fwdB_hit;
  logic [DW-1:0] fwdA_data;
  logic [DW-1:0] fwdB_data;
`endif
  logic [4:0]    rd;
  logic [DW-1:0] busC;
  logic [$clog2(DEPTH):0] ld_count;

  wb_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk(clk), .reset(reset), .wb_stall(wb_stall),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .qA(qA), .qB(qB),
    .busyA(busyA), .busyB(busyB),
`ifdef WB_FWD_EN
    .fwdA_hit(fwdA_hit), .fwdB_hit(fwdB_hit), .fwdA_data(fwdA_data), .fwdB_data(fwdB_data),
`endif
    .rd(rd), .busC(busC), .ld_count(ld_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          m_q[$];
  logic [31:0]   m_sb = '0;
  logic [4:0]    m_rd = '0;
  logic [DW-1:0] m_bus = '0;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_sb  = '0;
    m_rd  = '0;
    m_bus = '0;
  endtask

  task automatic model_edge();
    ent_t e;
    bit   push;
    if (reset) begin
      model_reset();
      return;
    end
    push = ld_valid && (m_q.size() < DEPTH);
    if (wb_stall) begin
      m_rd = 5'd0;
    end else if (alu_valid) begin
      m_rd  = alu_rd;
      m_bus = alu_data;
    end else if (m_q.size() > 0) begin
      e     = m_q.pop_front();
      m_rd  = e.rd;
      m_bus = e.d;
    end else begin
      m_rd = 5'd0;
    end
    if (push) begin
      e.rd = ld_rd;
      e.d  = ld_data;
      m_q.push_back(e);
    end
    if (m_rd != 0) m_sb[m_rd] = 1'b0;
    if (iss_valid && iss_rd != 0) m_sb[iss_rd] = 1'b1;
  endtask

  task automatic check_outputs();
    bit hit_a;
    bit hit_b;
`ifdef WB_FWD_EN
    hit_a = (m_rd != 0) && (m_rd == qA);
    hit_b = (m_rd != 0) && (m_rd == qB);
    chk("fwdA_hit", fwdA_hit, hit_a);
    chk("fwdB_hit", fwdB_hit, hit_b);
    chk("fwdA_data", fwdA_data, m_bus);
    chk("fwdB_data", fwdB_data, m_bus);
`else
    hit_a = 1'b0;
    hit_b = 1'b0;
`endif
    chk("rd", rd, m_rd);
    chk("busC", busC, m_bus);
    chk("ld_count", ld_count, m_q.size());
    chk("ld_ready", ld_ready, m_q.size() < DEPTH);
    chk("alu_ready", alu_ready, !wb_stall);
    chk("busyA", busyA, m_sb[qA] && !hit_a);
    chk("busyB", busyB, m_sb[qB] && !hit_b);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic idle();
    wb_stall  = 1'b0;
    alu_valid = 1'b0;
    ld_valid  = 1'b0;
    iss_valid = 1'b0;
  endtask

  initial begin
    // power-on reset
    #2 reset = 1'b1;
    #1 model_reset();
    check_outputs();
    @(negedge clk) reset = 1'b0;
    cycle();

    // ALU priority over queued loads
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAAAA0003;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h7777_0007;
    cycle();
    chk("prio_alu1", rd, 3);
    ld_rd = 5'd8; ld_data = 32'h8888_0008;
    cycle();
    ld_valid = 1'b0;
    cycle();
    cycle();
    chk("prio_alu4", rd, 3);
    chk("prio_cnt", ld_count, 2);
    alu_valid = 1'b0;
    cycle();
    chk("prio_ld7", rd, 7);
    cycle();
    chk("prio_ld8", rd, 8);
    chk("prio_ld8_data", busC, 32'h8888_0008);

    // queue fill to DEPTH, fifth load dropped, then drain
    alu_valid = 1'b1; alu_rd = 5'd1; ld_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ld_rd = 5'(20 + i); ld_data = 32'hF000_0000 + i;
      cycle();
    end
    chk("full_ready", ld_ready, 0);
    chk("full_cnt", ld_count, DEPTH);
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      cycle();
      chk("drain_rd", rd, 20 + i);
    end
    cycle();
    chk("drain_empty", rd, 0);

    // stall freezes the writeback slot
    wb_stall = 1'b1; alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h0000_0444;
    cycle();
    chk("stall_ready", alu_ready, 0);
    chk("stall_rd", rd, 0);
    wb_stall = 1'b0;
    cycle();
    chk("stall_release", rd, 4);
    idle();

    // scoreboard set/clear, same-cycle set wins, register 0 never busy
    qA = 5'd9; qB = 5'd0;
    iss_valid = 1'b1; iss_rd = 5'd9;
    cycle();
    iss_valid = 1'b0;
    cycle();
    chk("sb_pending", busyA, 1);
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h9;
    cycle();
    chk("sb_commit", busyA, 0);
    alu_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd9;
    cycle();
    alu_valid = 1'b1;
    cycle();
    idle();
    cycle();
    chk("sb_set_wins", busyA, 1);
    iss_valid = 1'b1; iss_rd = 5'd0; qA = 5'd0;
    cycle();
    chk("sb_zero", busyA, 0);
    idle();

    // forwarding window on commit
    qA = 5'd12; iss_valid = 1'b1; iss_rd = 5'd12;
    cycle();
    iss_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h12345678;
    cycle();
    chk("fwd_busy", busyA, 0);
`ifdef WB_FWD_EN
    chk("fwd_hit", fwdA_hit, 1);
    chk("fwd_data", fwdA_data, 32'h12345678);
`endif
    idle();

    // asynchronous reset mid-operation
    alu_valid = 1'b1; alu_rd = 5'd2; ld_valid = 1'b1; iss_valid = 1'b1; iss_rd = 5'd5;
    for (int i = 0; i < 3; i++) begin
      ld_rd = 5'(10 + i); ld_data = 32'hB0 + i;
      cycle();
    end
    idle();
    qA = 5'd5;
    #1;
    chk("pre_reset_busy", busyA, 1);
    reset = 1'b1;
    #1 model_reset();
    chk("rst_rd", rd, 0);
    chk("rst_busC", busC, 0);
    chk("rst_cnt", ld_count, 0);
    chk("rst_busyA", busyA, 0);
    cycle();
    @(negedge clk) reset = 1'b0;

    // random traffic
    for (int n = 0; n < 600; n++) begin
      wb_stall  = ($urandom_range(0, 7) == 0);
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_rd    = 5'($urandom_range(0, 15));
      alu_data  = $urandom;
      ld_valid  = ($urandom_range(0, 1) == 0);
      ld_rd     = 5'($urandom_range(0, 15));
      ld_data   = $urandom;
      iss_valid = ($urandom_range(0, 1) == 0);
      iss_rd    = 5'($urandom_range(0, 15));
      qA        = 5'($urandom_range(0, 15));
      qB        = 5'($urandom_range(0, 15));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
